// File: rtl/lc3_mem_responder.sv
// LC-3 MAR/MDR memory responder: IDLE/WAIT/DONE handshake with programmable wait states.
// Define LC3_MMIO_EN to compile in the KBSR/KBDR/DSR/DDR device registers at FE00-FE06.
module lc3_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic        memEN,
    input  logic        memRW,
    output logic [15:0] mem_data,
    output logic        memR,
    input  logic [7:0]  kbd_data,
    input  logic        kbd_valid,
    output logic [7:0]  disp_data,
    output logic        disp_valid,
    input  logic        disp_ready
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [15:0]         r_mar;
    logic [15:0]         r_mdr;
    logic                r_rw;
    logic [15:0]         r_ram [2**ADDR_W];

    logic [ADDR_W-1:0]   w_idx;
    logic                w_access;
    logic                w_dev_hit;
    logic [15:0]         w_dev_rdata;
    logic [15:0]         w_rd_data;
    logic                w_ram_we;

    assign w_idx     = r_mar[ADDR_W-1:0];
    assign w_access  = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_ram_we  = w_access && r_rw && !w_dev_hit;
    assign w_rd_data = w_dev_hit ? w_dev_rdata : r_ram[w_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_mar    <= '0;
            r_mdr    <= '0;
            r_rw     <= 1'b0;
            mem_data <= 16'h0000;
            memR     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (memEN) begin
                        r_mar   <= MAR;
                        r_mdr   <= MDR;
                        r_rw    <= memRW;
                        r_cnt   <= 4'(WAIT_CYCLES);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The captured request completes even if memEN has already dropped.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_rw) mem_data <= w_rd_data;
                        memR    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!memEN) begin
                        memR    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    memR    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // RAM is not reset; a reset before the access edge leaves the FSM out of WAIT, so no write.
    always_ff @(posedge clk) begin
        if (w_ram_we) r_ram[w_idx] <= r_mdr;
    end

`ifdef LC3_MMIO_EN
    logic       r_kbsr;
    logic       r_dsr;
    logic [7:0] r_kbd_byte;
    logic       w_rd_op;
    logic       w_wr_op;

    assign w_rd_op   = w_access && !r_rw;
    assign w_wr_op   = w_access && r_rw;
    assign w_dev_hit = (r_mar == 16'hFE00) || (r_mar == 16'hFE02) ||
                       (r_mar == 16'hFE04) || (r_mar == 16'hFE06);

    always_comb begin
        w_dev_rdata = 16'h0000;
        case (r_mar)
            16'hFE00: w_dev_rdata = {r_kbsr, 15'b0};
            16'hFE02: w_dev_rdata = {8'h00, r_kbd_byte};
            16'hFE04: w_dev_rdata = {r_dsr, 15'b0};
            default:  w_dev_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kbsr     <= 1'b0;
            r_dsr      <= 1'b1;
            r_kbd_byte <= 8'h00;
            disp_data  <= 8'h00;
            disp_valid <= 1'b0;
        end else begin
            disp_valid <= 1'b0;
            // A fresh key wins over a simultaneous KBDR read so the new byte is not lost.
            if (kbd_valid) begin
                r_kbd_byte <= kbd_data;
                r_kbsr     <= 1'b1;
            end else if (w_rd_op && r_mar == 16'hFE02) begin
                r_kbsr <= 1'b0;
            end
            if (w_wr_op && r_mar == 16'hFE06) begin
                disp_data  <= r_mdr[7:0];
                disp_valid <= 1'b1;
                r_dsr      <= 1'b0;
            end else if (disp_ready) begin
                r_dsr <= 1'b1;
            end
        end
    end
`else
    logic w_unused_mmio;

    assign w_dev_hit     = 1'b0;
    assign w_dev_rdata   = 16'h0000;
    assign disp_data     = 8'h00;
    assign disp_valid    = 1'b0;
    assign w_unused_mmio = ^{kbd_data, kbd_valid, disp_ready, r_mar[15:ADDR_W]};
`endif

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: handshake latency, hold, aliasing, reset abort, MMIO.
module tb_lc3_mem_responder;

    localparam int WAIT_CYCLES = 2;
    localparam int LAT         = WAIT_CYCLES + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] MAR = '0;
    logic [15:0] MDR = '0;
    logic        memEN = 1'b0;
    logic        memRW = 1'b0;
    logic [15:0] mem_data;
    logic        memR;
    logic [7:0]  kbd_data = '0;
    logic        kbd_valid = 1'b0;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        disp_ready = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int dv_cnt = 0;

    lc3_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .reset(reset), .MAR(MAR), .MDR(MDR), .memEN(memEN), .memRW(memRW),
        .mem_data(mem_data), .memR(memR), .kbd_data(kbd_data), .kbd_valid(kbd_valid),
        .disp_data(disp_data), .disp_valid(disp_valid), .disp_ready(disp_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (disp_valid === 1'b1) dv_cnt <= dv_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full handshake; lat counts edges from acceptance to memR, hold keeps memEN up longer.
    task automatic access(input logic [15:0] a, input logic [15:0] d, input logic rw,
                          input int hold, output logic [15:0] rd, output int lat);
        @(negedge clk);
        MAR = a; MDR = d; memRW = rw; memEN = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!memR && lat < 40);
        lat--;
        rd = mem_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_memR", {31'b0, memR}, 32'd1);
        end
        @(negedge clk);
        memEN = 1'b0;
        @(posedge clk); #1;
        chk("memR_fall", {31'b0, memR}, 32'd0);
    endtask

    logic [15:0] rd;
    int          lat;
    int          dv0;

    initial begin
        #12;
        chk("rst_memR", {31'b0, memR}, 32'd0);
        chk("rst_mem_data", {16'b0, mem_data}, 32'h0000);
        chk("rst_disp_data", {24'b0, disp_data}, 32'h00);
        chk("rst_disp_valid", {31'b0, disp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        access(16'h0010, 16'hBEEF, 1'b1, 0, rd, lat);
        chk("wr_lat", lat, LAT);
        access(16'h0010, 16'h0000, 1'b0, 0, rd, lat);
        chk("rd_lat", lat, LAT);
        chk("rd_beef", {16'b0, rd}, 32'hBEEF);

        access(16'h0010, 16'h0000, 1'b0, 8, rd, lat);
        chk("hold_data", {16'b0, rd}, 32'hBEEF);
        access(16'h0010, 16'h0000, 1'b0, 0, rd, lat);
        chk("after_hold_lat", lat, LAT);

        access(16'h0005, 16'h1234, 1'b1, 0, rd, lat);
        access(16'h0405, 16'h0000, 1'b0, 0, rd, lat);
        chk("alias_0405", {16'b0, rd}, 32'h1234);

        access(16'h0020, 16'h5555, 1'b1, 0, rd, lat);
        access(16'h0010, 16'h0000, 1'b0, 0, rd, lat);
        // Abort a write of AAAA while it sits in WAIT.
        @(negedge clk);
        MAR = 16'h0020; MDR = 16'hAAAA; memRW = 1'b1; memEN = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort_memR", {31'b0, memR}, 32'd0);
        chk("abort_mem_data", {16'b0, mem_data}, 32'h0000);
        memEN = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        access(16'h0020, 16'h0000, 1'b0, 0, rd, lat);
        chk("abort_ram_kept", {16'b0, rd}, 32'h5555);

`ifdef LC3_MMIO_EN
        access(16'hFE04, 16'h0000, 1'b0, 0, rd, lat);
        chk("dsr_reset", {16'b0, rd}, 32'h8000);
        access(16'hFE00, 16'h0000, 1'b0, 0, rd, lat);
        chk("kbsr_reset", {16'b0, rd}, 32'h0000);
        @(negedge clk);
        kbd_data = 8'h41; kbd_valid = 1'b1;
        @(negedge clk);
        kbd_valid = 1'b0;
        access(16'hFE00, 16'h0000, 1'b0, 0, rd, lat);
        chk("kbsr_set", {16'b0, rd}, 32'h8000);
        access(16'hFE02, 16'h0000, 1'b0, 0, rd, lat);
        chk("kbdr", {16'b0, rd}, 32'h0041);
        access(16'hFE00, 16'h0000, 1'b0, 0, rd, lat);
        chk("kbsr_clr", {16'b0, rd}, 32'h0000);

        dv0 = dv_cnt;
        access(16'hFE06, 16'h0058, 1'b1, 0, rd, lat);
        chk("ddr_lat", lat, LAT);
        chk("disp_valid_cnt", dv_cnt - dv0, 32'd1);
        chk("disp_data", {24'b0, disp_data}, 32'h58);
        access(16'hFE04, 16'h0000, 1'b0, 0, rd, lat);
        chk("dsr_busy", {16'b0, rd}, 32'h0000);
        access(16'hFE06, 16'h0000, 1'b0, 0, rd, lat);
        chk("ddr_read", {16'b0, rd}, 32'h0000);
        access(16'hFE04, 16'h0000, 1'b0, 0, rd, lat);
        chk("dsr_still_busy", {16'b0, rd}, 32'h0000);
        @(negedge clk);
        disp_ready = 1'b1;
        @(negedge clk);
        disp_ready = 1'b0;
        access(16'hFE04, 16'h0000, 1'b0, 0, rd, lat);
        chk("dsr_ready", {16'b0, rd}, 32'h8000);
`else
        dv0 = dv_cnt;
        access(16'hFE06, 16'h0058, 1'b1, 0, rd, lat);
        chk("no_mmio_disp_valid", dv_cnt - dv0, 32'd0);
        chk("no_mmio_disp_data", {24'b0, disp_data}, 32'h00);
        access(16'h3E06, 16'h0000, 1'b0, 0, rd, lat);
        chk("no_mmio_alias", {16'b0, rd}, 32'h0058);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
